// File: rtl/prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// prog_run_ctrl
//
// Boot-and-run sequencer for the single-cycle MIPS core. On an accepted start
// it zero-fills the whole program memory, streams a host program into it over
// a valid/ready handshake, holds the core in clear for RST_HOLD cycles and then
// lets it run until a cycle budget expires or the host requests a halt.
//
// Ports
//   clk_in      : clock, rising edge
//   clr_n       : asynchronous active-low reset
//   start       : begin wipe/load/run (looked at only in IDLE or HALTED)
//   load_len    : number of words to load, 0..MEM_DEPTH (latched on start)
//   step_limit  : run budget in cycles, 0 = unlimited (latched on start)
//   host_valid  : host word valid
//   host_data   : host word
//   host_ready  : controller accepts a word this cycle
//   halt_req    : stop the run (looked at only in RUN)
//   prog_write  : program memory write enable
//   prog_addr   : program memory write address
//   prog_data   : program memory write data
//   cpu_clr     : active-high clear to the core
//   cpu_en      : core run enable
//   busy        : in WIPE, LOAD, RESET_CPU or RUN
//   done        : in HALTED
//   err         : last start was rejected (load_len > MEM_DEPTH)
//   run_cycles  : enabled cycles of the current/last run, saturating
//
// Every output is a register; the next values are formed in one combinational
// block so each state transition sets all of its outputs together.
// -----------------------------------------------------------------------------
module prog_run_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int RST_HOLD  = 2
) (
  input  logic              clk_in,
  input  logic              clr_n,
  input  logic              start,
  input  logic [ADDR_W:0]   load_len,
  input  logic [15:0]       step_limit,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              halt_req,
  output logic              prog_write,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [DATA_W-1:0] prog_data,
  output logic              cpu_clr,
  output logic              cpu_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       run_cycles
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_WIPE      = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_RESET_CPU = 3'd3;
  localparam logic [2:0] ST_RUN       = 3'd4;
  localparam logic [2:0] ST_HALTED    = 3'd5;

  // Hold counter only needs to reach RST_HOLD-1.
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  // State and bookkeeping registers
  logic [2:0]        state_reg,      state_next;
  logic [ADDR_W:0]   len_reg,        len_next;
  logic [15:0]       limit_reg,      limit_next;
  logic [ADDR_W:0]   cnt_reg,        cnt_next;
  logic [HOLD_W-1:0] hold_reg,       hold_next;

  // Output registers
  logic              host_ready_reg, host_ready_next;
  logic              prog_write_reg, prog_write_next;
  logic [ADDR_W-1:0] prog_addr_reg,  prog_addr_next;
  logic [DATA_W-1:0] prog_data_reg,  prog_data_next;
  logic              cpu_clr_reg,    cpu_clr_next;
  logic              cpu_en_reg,     cpu_en_next;
  logic              busy_reg,       busy_next;
  logic              done_reg,       done_next;
  logic              err_reg,        err_next;
  logic [15:0]       run_cycles_reg, run_cycles_next;

  // Helpers
  logic [ADDR_W:0]   cnt_inc;
  logic [16:0]       run_inc;
  logic [15:0]       run_sat;
  logic              limit_hit;
  logic              handshake;

  assign cnt_inc   = cnt_reg + (ADDR_W + 1)'(1);
  assign handshake = host_valid && host_ready_reg;

  // run_inc is the count including the cycle that ends at this edge, so the
  // budget compare fires on the edge that completes the last allowed cycle.
  assign run_inc   = {1'b0, run_cycles_reg} + 17'd1;
  assign run_sat   = run_inc[16] ? 16'hFFFF : run_inc[15:0];
  assign limit_hit = (limit_reg != 16'd0) && (run_inc == {1'b0, limit_reg});

  always_comb begin
    state_next      = state_reg;
    len_next        = len_reg;
    limit_next      = limit_reg;
    cnt_next        = cnt_reg;
    hold_next       = hold_reg;
    host_ready_next = host_ready_reg;
    prog_write_next = prog_write_reg;
    prog_addr_next  = prog_addr_reg;
    prog_data_next  = prog_data_reg;
    cpu_clr_next    = cpu_clr_reg;
    cpu_en_next     = cpu_en_reg;
    busy_next       = busy_reg;
    done_next       = done_reg;
    err_next        = err_reg;
    run_cycles_next = run_cycles_reg;

    case (state_reg)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          if (load_len > DEPTH_LEN) begin
            // Rejected: stay put, only flag the error.
            err_next = 1'b1;
          end else begin
            len_next        = load_len;
            limit_next      = step_limit;
            cnt_next        = '0;
            err_next        = 1'b0;
            run_cycles_next = 16'd0;
            cpu_clr_next    = 1'b1;
            cpu_en_next     = 1'b0;
            busy_next       = 1'b1;
            done_next       = 1'b0;
            // First wipe write is presented in the very next cycle.
            prog_write_next = 1'b1;
            prog_addr_next  = '0;
            prog_data_next  = '0;
            state_next      = ST_WIPE;
          end
        end
      end

      ST_WIPE: begin
        if (prog_addr_reg == LAST_ADDR) begin
          prog_write_next = 1'b0;
          prog_addr_next  = '0;
          if (len_reg == '0) begin
            hold_next  = '0;
            state_next = ST_RESET_CPU;
          end else begin
            host_ready_next = 1'b1;
            state_next      = ST_LOAD;
          end
        end else begin
          prog_addr_next = prog_addr_reg + ADDR_W'(1);
        end
      end

      ST_LOAD: begin
        // A write is shown for exactly one cycle after each handshake.
        prog_write_next = 1'b0;
        if (handshake) begin
          prog_write_next = 1'b1;
          prog_addr_next  = cnt_reg[ADDR_W-1:0];
          prog_data_next  = host_data;
          cnt_next        = cnt_inc;
          if (cnt_inc == len_reg) begin
            host_ready_next = 1'b0;
            hold_next       = '0;
            state_next      = ST_RESET_CPU;
          end
        end
      end

      ST_RESET_CPU: begin
        // Clears the final load write, which lands in the first cycle here.
        prog_write_next = 1'b0;
        if (hold_reg == HOLD_LAST) begin
          cpu_clr_next = 1'b0;
          cpu_en_next  = 1'b1;
          state_next   = ST_RUN;
        end else begin
          hold_next = hold_reg + HOLD_W'(1);
        end
      end

      ST_RUN: begin
        run_cycles_next = run_sat;
        // Halt request and budget expiry both land in the same HALTED entry.
        if (halt_req || limit_hit) begin
          cpu_en_next = 1'b0;
          busy_next   = 1'b0;
          done_next   = 1'b1;
          state_next  = ST_HALTED;
        end
      end

      default: begin
        state_next      = ST_IDLE;
        host_ready_next = 1'b0;
        prog_write_next = 1'b0;
        cpu_clr_next    = 1'b1;
        cpu_en_next     = 1'b0;
        busy_next       = 1'b0;
        done_next       = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge clr_n) begin
    if (!clr_n) begin
      state_reg      <= ST_IDLE;
      len_reg        <= '0;
      limit_reg      <= 16'd0;
      cnt_reg        <= '0;
      hold_reg       <= '0;
      host_ready_reg <= 1'b0;
      prog_write_reg <= 1'b0;
      prog_addr_reg  <= '0;
      prog_data_reg  <= '0;
      cpu_clr_reg    <= 1'b1;
      cpu_en_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      err_reg        <= 1'b0;
      run_cycles_reg <= 16'd0;
    end else begin
      state_reg      <= state_next;
      len_reg        <= len_next;
      limit_reg      <= limit_next;
      cnt_reg        <= cnt_next;
      hold_reg       <= hold_next;
      host_ready_reg <= host_ready_next;
      prog_write_reg <= prog_write_next;
      prog_addr_reg  <= prog_addr_next;
      prog_data_reg  <= prog_data_next;
      cpu_clr_reg    <= cpu_clr_next;
      cpu_en_reg     <= cpu_en_next;
      busy_reg       <= busy_next;
      done_reg       <= done_next;
      err_reg        <= err_next;
      run_cycles_reg <= run_cycles_next;
    end
  end

  assign host_ready = host_ready_reg;
  assign prog_write = prog_write_reg;
  assign prog_addr  = prog_addr_reg;
  assign prog_data  = prog_data_reg;
  assign cpu_clr    = cpu_clr_reg;
  assign cpu_en     = cpu_en_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign err        = err_reg;
  assign run_cycles = run_cycles_reg;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// -----------------------------------------------------------------------------
// tb_prog_run_ctrl
//
// Directed sequence of boot/run scenarios. Each scenario's expected waveform is
// derived from a timeline: wipe cycles, the cycles in which the host handshakes
// happen (from the bench's own valid pattern), the clear-hold window, and the
// run length (budget or halt, whichever is first). Every cycle of a scenario is
// compared against that timeline.
// -----------------------------------------------------------------------------
module tb_prog_run_ctrl;

  localparam int DEPTH = 256;
  localparam int HOLD  = 2;

  logic        clk_in = 1'b0;
  logic        clr_n;
  logic        start;
  logic [8:0]  load_len;
  logic [15:0] step_limit;
  logic        host_valid;
  logic [31:0] host_data;
  logic        host_ready;
  logic        halt_req;
  logic        prog_write;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        cpu_clr;
  logic        cpu_en;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] run_cycles;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk_in = ~clk_in;

  prog_run_ctrl #(
    .ADDR_W(8), .DATA_W(32), .MEM_DEPTH(DEPTH), .RST_HOLD(HOLD)
  ) dut (
    .clk_in(clk_in), .clr_n(clr_n), .start(start), .load_len(load_len),
    .step_limit(step_limit), .host_valid(host_valid), .host_data(host_data),
    .host_ready(host_ready), .halt_req(halt_req), .prog_write(prog_write),
    .prog_addr(prog_addr), .prog_data(prog_data), .cpu_clr(cpu_clr),
    .cpu_en(cpu_en), .busy(busy), .done(done), .err(err),
    .run_cycles(run_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT in IDLE or HALTED; that cycle is cycle 0.
  task automatic run_prog(input int len, input int limit, input int halt_at,
                          input int vmode, input bit stray, input bit fixed_words);
    logic [31:0] words[$];
    bit          valid_q[$];
    int          hs_cyc[$];
    int k, acc, k_last, rst_start, run_start, halt_cyc, r_len, ld_acc, lk;
    bit v, exp_wr;
    logic [31:0] exp_addr, exp_data;

    for (int i = 0; i < len; i++)
      words.push_back(fixed_words ? 32'h20080001 + 32'(i) : $urandom);
    acc = 0;
    k   = 0;
    while (acc < len) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (k % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      valid_q.push_back(v);
      if (v) begin
        hs_cyc.push_back(DEPTH + 1 + k);
        acc++;
      end
      k++;
    end
    k_last    = k - 1;
    rst_start = (len > 0) ? DEPTH + 2 + k_last : DEPTH + 1;
    run_start = rst_start + HOLD;
    if (limit == 0)                          r_len = halt_at;
    else if (halt_at == 0 || halt_at > limit) r_len = limit;
    else                                      r_len = halt_at;
    halt_cyc = run_start + r_len;
    $display("run: len=%0d limit=%0d halt_at=%0d vmode=%0d run_start=%0d expected_run_cycles=%0d",
             len, limit, halt_at, vmode, run_start, r_len);

    start      = 1'b1;
    load_len   = 9'(len);
    step_limit = 16'(limit);
    halt_req   = 1'b0;
    host_valid = 1'(($urandom % 2));
    host_data  = $urandom;
    ld_acc     = 0;

    for (int c = 1; c <= halt_cyc + 3; c++) begin
      @(negedge clk_in);
      cyc = c;
      exp_wr   = 1'b0;
      exp_addr = 32'd0;
      exp_data = 32'd0;
      if (c <= DEPTH) begin
        exp_wr   = 1'b1;
        exp_addr = 32'(c - 1);
      end else begin
        for (int j = 0; j < hs_cyc.size(); j++)
          if (hs_cyc[j] + 1 == c) begin
            exp_wr   = 1'b1;
            exp_addr = 32'(j);
            exp_data = words[j];
          end
      end
      chk("prog_write", 32'(prog_write), 32'(exp_wr));
      if (exp_wr) begin
        chk("prog_addr", 32'(prog_addr), exp_addr);
        chk("prog_data", prog_data, exp_data);
      end
      chk("host_ready", 32'(host_ready), 32'(len > 0 && c >= DEPTH + 1 && c <= DEPTH + 1 + k_last));
      chk("cpu_clr", 32'(cpu_clr), 32'(c < run_start));
      chk("cpu_en", 32'(cpu_en), 32'(c >= run_start && c < halt_cyc));
      chk("busy", 32'(busy), 32'(c < halt_cyc));
      chk("done", 32'(done), 32'(c >= halt_cyc));
      chk("err", 32'(err), 32'd0);
      chk("run_cycles", 32'(run_cycles),
          32'((c <= run_start) ? 0 : ((c <= halt_cyc) ? c - run_start : r_len)));

      // Inputs for the edge that ends cycle c.
      start      = stray && (c < halt_cyc) && ($urandom % 4 == 0);
      load_len   = 9'($urandom_range(0, 511));
      step_limit = 16'($urandom);
      halt_req   = (halt_at != 0 && c == run_start + halt_at - 1) ||
                   (stray && (c < run_start || c >= halt_cyc) && ($urandom % 5 == 0));
      lk = c - DEPTH - 1;
      if (len > 0 && lk >= 0 && lk <= k_last) begin
        host_valid = valid_q[lk];
        host_data  = valid_q[lk] ? words[ld_acc] : $urandom;
        if (valid_q[lk]) ld_acc++;
      end else begin
        host_valid = 1'(($urandom % 2));
        host_data  = $urandom;
      end
    end
    start    = 1'b0;
    halt_req = 1'b0;
  endtask

  // Rejected start: state, outputs and memory writes must not change.
  task automatic bad_len(input int len, input bit exp_done, input bit exp_clr);
    @(negedge clk_in);
    start    = 1'b1;
    load_len = 9'(len);
    $display("bad start: load_len=%0d", len);
    @(negedge clk_in);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc = i;
      chk("bad_err", 32'(err), 32'd1);
      chk("bad_busy", 32'(busy), 32'd0);
      chk("bad_done", 32'(done), 32'(exp_done));
      chk("bad_prog_write", 32'(prog_write), 32'd0);
      chk("bad_cpu_en", 32'(cpu_en), 32'd0);
      chk("bad_cpu_clr", 32'(cpu_clr), 32'(exp_clr));
      chk("bad_host_ready", 32'(host_ready), 32'd0);
      @(negedge clk_in);
    end
  endtask

  initial begin
    int len, limit, halt_at;
    clr_n      = 1'b0;
    start      = 1'b0;
    load_len   = '0;
    step_limit = '0;
    host_valid = 1'b0;
    host_data  = '0;
    halt_req   = 1'b0;

    // Power-on reset values
    @(negedge clk_in);
    chk("rst_cpu_clr", 32'(cpu_clr), 32'd1);
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prog_write", 32'(prog_write), 32'd0);
    chk("rst_host_ready", 32'(host_ready), 32'd0);
    chk("rst_run_cycles", 32'(run_cycles), 32'd0);
    clr_n = 1'b1;

    // Reset asserted mid-RUN
    @(negedge clk_in);
    start      = 1'b1;
    load_len   = 9'd0;
    step_limit = 16'd0;
    @(negedge clk_in);
    start = 1'b0;
    repeat (DEPTH + HOLD + 3) @(negedge clk_in);
    chk("midrun_cpu_en", 32'(cpu_en), 32'd1);
    chk("midrun_run_cycles", 32'(run_cycles), 32'd3);
    #2 clr_n = 1'b0;
    #1;
    $display("async reset asserted mid-run");
    chk("arst_cpu_en", 32'(cpu_en), 32'd0);
    chk("arst_cpu_clr", 32'(cpu_clr), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_run_cycles", 32'(run_cycles), 32'd0);
    @(negedge clk_in);
    clr_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      chk("idle_prog_write", 32'(prog_write), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_cpu_clr", 32'(cpu_clr), 32'd1);
    end

    // Bad length from IDLE
    bad_len(257, 1'b0, 1'b1);

    // Wipe with zero-length load and a 5-cycle budget
    run_prog(0, 5, 0, 0, 1'b0, 1'b0);
    // Stalled load, valid every other cycle
    run_prog(8, 20, 0, 1, 1'b0, 1'b1);
    // Halt before budget, then halt coinciding with budget
    run_prog(3, 10, 4, 0, 1'b0, 1'b0);
    run_prog(3, 10, 10, 0, 1'b0, 1'b0);
    // Bad length from HALTED, then valid start clears err
    bad_len(257, 1'b1, 1'b0);
    // Full-depth reload from HALTED with stray start/halt/valid
    run_prog(256, 7, 0, 2, 1'b1, 1'b0);
    // Randomised scenarios
    for (int r = 0; r < 3; r++) begin
      len   = $urandom_range(1, 40);
      limit = $urandom_range(0, 30);
      if (limit == 0) halt_at = $urandom_range(1, 30);
      else            halt_at = $urandom_range(0, 35);
      run_prog(len, limit, halt_at, 2, 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
